// File: rtl/wave_table_loader.sv
// Waveform table feeder for the DDS engine: emits exactly 256 samples per load,
// either a built-in shape or host-streamed bytes, zero-filling on abort.
module wave_table_loader #(
    parameter int unsigned GAP = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] wave_sel,
    input  logic [7:0] duty,
    input  logic       abort,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic       wave_wr_pulse,
    output logic [7:0] wave_data,
    output logic       busy,
    output logic       done,
    output logic       last_aborted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_STREAM,
        S_FILL,
        S_DONE
    } state_t;

    localparam logic [7:0] GAP_V = 8'(GAP);

    state_t     state_q, state_d;
    logic [8:0] idx_q, idx_d;
    logic [7:0] gap_q, gap_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] duty_q, duty_d;
    logic       wr_q, wr_d;
    logic [7:0] data_q, data_d;
    logic       done_q, done_d;
    logic       lab_q, lab_d;

    function automatic logic [7:0] gen_sample(input logic [1:0] sel, input logic [7:0] dty,
                                              input logic [7:0] ix);
        logic [7:0] ti;
        ti = 8'd255 - ix;
        case (sel)
            2'd0:    gen_sample = (ix < dty) ? 8'hFF : 8'h00;
            2'd1:    gen_sample = ix[7] ? {ti[6:0], 1'b0} : {ix[6:0], 1'b0};
            2'd2:    gen_sample = ix;
            default: gen_sample = 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = (gap_q != 8'd0) ? gap_q - 8'd1 : 8'd0;
        sel_d   = sel_q;
        duty_d  = duty_q;
        wr_d    = 1'b0;
        data_d  = 8'h00;
        done_d  = 1'b0;
        lab_d   = lab_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    sel_d   = wave_sel;
                    duty_d  = duty;
                    idx_d   = 9'd0;
                    gap_d   = 8'd0;
                    lab_d   = 1'b0;
                    state_d = (wave_sel == 2'd3) ? S_STREAM : S_GEN;
                end
            end
            S_GEN, S_STREAM, S_FILL: begin
                if (abort && state_q != S_FILL) begin
                    state_d = S_FILL;
                    lab_d   = 1'b1;
                end else if (gap_q == 8'd0 && (state_q != S_STREAM || s_valid)) begin
                    wr_d  = 1'b1;
                    idx_d = idx_q + 9'd1;
                    gap_d = GAP_V;
                    if (state_q == S_GEN)    data_d = gen_sample(sel_q, duty_q, idx_q[7:0]);
                    if (state_q == S_STREAM) data_d = s_data;
                    if (idx_q == 9'd255)     state_d = S_DONE;
                end
            end
            S_DONE: begin
                // first DONE cycle carries the final pulse; done follows one cycle later
                if (done_q) state_d = S_IDLE;
                else        done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 9'd0;
            gap_q   <= 8'd0;
            sel_q   <= 2'd0;
            duty_q  <= 8'd0;
            wr_q    <= 1'b0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            lab_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            sel_q   <= sel_d;
            duty_q  <= duty_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            lab_q   <= lab_d;
        end
    end

    assign s_ready       = (state_q == S_STREAM) && (gap_q == 8'd0) && !abort;
    assign busy          = (state_q != S_IDLE);
    assign wave_wr_pulse = wr_q;
    assign wave_data     = data_q;
    assign done          = done_q;
    assign last_aborted  = lab_q;

endmodule

// File: tb/tb_wave_table_loader.sv
// Bench for wave_table_loader: three instances (GAP=0,1,2) sharing stimulus,
// each load checked on one instance against a spec-level timing/data model.
module tb_wave_table_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] wave_sel = 2'd0;
    logic [7:0] duty = 8'd0;
    logic       abort = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'd0;

    logic       s_ready_w [3];
    logic       wr_w      [3];
    logic [7:0] data_w    [3];
    logic       busy_w    [3];
    logic       done_w    [3];
    logic       lab_w     [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wave_table_loader #(.GAP(g)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .start        (start),
            .wave_sel     (wave_sel),
            .duty         (duty),
            .abort        (abort),
            .s_valid      (s_valid),
            .s_data       (s_data),
            .s_ready      (s_ready_w[g]),
            .wave_wr_pulse(wr_w[g]),
            .wave_data    (data_w[g]),
            .busy         (busy_w[g]),
            .done         (done_w[g]),
            .last_aborted (lab_w[g])
        );
    end

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    logic [7:0] cap [256];

    typedef struct {
        logic [1:0] sel;
        logic [7:0] dty;
        int         g;
        int         idx;
        logic [7:0] exp;
    } vec_t;
    vec_t vt [19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_sample(input logic [1:0] sel, input logic [7:0] dty, input int k);
        case (sel)
            2'd0:    return (k < int'(dty)) ? 8'hFF : 8'h00;
            2'd1:    return (k < 128) ? 8'(2 * k) : 8'(2 * (255 - k));
            2'd2:    return 8'(k);
            default: return 8'h00;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // One full load on instance g; abort_after>=0 aborts once that many pulses were seen.
    task automatic run_load(input string nm, input int g, input logic [1:0] sel, input logic [7:0] dty,
                            input int vprob, input int abort_after, input bit restart, input bit do_rst);
        int n, np, nhs, last_n, last_hs, abort_np, n_done;
        int e_time, e_data, e_ready, e_done, e_busy, e_excl;
        bit aborted, hs, finished, exp_rdy, exp_busy;
        logic [7:0] bytes [$];
        logic [7:0] ed;
        if (do_rst) do_reset();
        @(negedge clk);
        start = 1'b1; wave_sel = sel; duty = dty; abort = 1'b0; s_valid = 1'b0;
        @(posedge clk); #1;
        n = 0; np = 0; nhs = 0; last_n = -1; last_hs = -1000; abort_np = 256; n_done = 0;
        e_time = 0; e_data = 0; e_ready = 0; e_done = 0; e_busy = 0; e_excl = 0;
        aborted = 0; finished = 0;
        bytes = {};
        while (!finished && n < 4000) begin
            @(negedge clk);
            start = restart && np < 255 && ($urandom_range(3) == 0);
            abort = 1'b0;
            if (abort_after >= 0 && !aborted && np == abort_after) begin
                abort = 1'b1; aborted = 1; abort_np = np;
            end
            s_valid = (sel == 2'd3) && (abort || $urandom_range(99) < vprob);
            s_data  = 8'($urandom);
            #1;
            exp_rdy = (sel == 2'd3) && !aborted && nhs < 256 && (n + 1 - last_hs > g);
            if (s_ready_w[g] !== exp_rdy) e_ready++;
            hs = s_valid && s_ready_w[g];
            if (hs) begin nhs++; last_hs = n + 1; bytes.push_back(s_data); end
            @(posedge clk); #1;
            n++;
            if (wr_w[g]) begin
                if (sel != 2'd3 && abort_after < 0 && n != 1 + np * (g + 1)) e_time++;
                if (sel == 2'd3 && !aborted && !hs) e_time++;
                if (last_n >= 0 && n - last_n < g + 1) e_time++;
                if (np >= abort_np)          ed = 8'h00;
                else if (sel != 2'd3)        ed = ref_sample(sel, dty, np);
                else if (np < bytes.size())  ed = bytes[np];
                else                         ed = ~data_w[g];
                if (data_w[g] !== ed) e_data++;
                if (np < 256) cap[np] = data_w[g];
                if (done_w[g]) e_excl++;
                np++;
                last_n = n;
            end else if (sel == 2'd3 && hs && !aborted) begin
                e_time++;
            end
            if (done_w[g]) begin
                n_done++;
                if (np != 256 || n != last_n + 1) e_done++;
            end
            exp_busy = !(np == 256 && n >= last_n + 2);
            if (busy_w[g] !== exp_busy) e_busy++;
            finished = (np >= 256 && n >= last_n + 3);
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; s_valid = 1'b0;
        chk({nm, "_timeout"}, 32'(finished), 32'd1);
        chk({nm, "_pulses"}, np, 256);
        chk({nm, "_data_err"}, e_data, 0);
        chk({nm, "_timing_err"}, e_time, 0);
        chk({nm, "_done_cnt"}, n_done, 1);
        chk({nm, "_done_err"}, e_done + e_excl, 0);
        chk({nm, "_busy_err"}, e_busy, 0);
        chk({nm, "_last_aborted"}, lab_w[g], 32'(aborted));
        if (sel == 2'd3) begin
            chk({nm, "_ready_err"}, e_ready, 0);
            chk({nm, "_handshakes"}, nhs, aborted ? abort_after : 256);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int pc, cyc;
        int g;
        vt[0]  = '{2'd2, 8'h00, 0, 0,   8'h00};
        vt[1]  = '{2'd2, 8'h00, 0, 1,   8'h01};
        vt[2]  = '{2'd2, 8'h00, 0, 128, 8'h80};
        vt[3]  = '{2'd2, 8'h00, 0, 255, 8'hFF};
        vt[4]  = '{2'd1, 8'h00, 0, 0,   8'h00};
        vt[5]  = '{2'd1, 8'h00, 0, 1,   8'h02};
        vt[6]  = '{2'd1, 8'h00, 0, 127, 8'hFE};
        vt[7]  = '{2'd1, 8'h00, 0, 128, 8'hFE};
        vt[8]  = '{2'd1, 8'h00, 0, 254, 8'h02};
        vt[9]  = '{2'd1, 8'h00, 0, 255, 8'h00};
        vt[10] = '{2'd0, 8'h40, 2, 0,   8'hFF};
        vt[11] = '{2'd0, 8'h40, 2, 63,  8'hFF};
        vt[12] = '{2'd0, 8'h40, 2, 64,  8'h00};
        vt[13] = '{2'd0, 8'h40, 2, 255, 8'h00};
        vt[14] = '{2'd0, 8'h00, 0, 0,   8'h00};
        vt[15] = '{2'd0, 8'h00, 0, 255, 8'h00};
        vt[16] = '{2'd0, 8'hFF, 0, 0,   8'hFF};
        vt[17] = '{2'd0, 8'hFF, 0, 254, 8'hFF};
        vt[18] = '{2'd0, 8'hFF, 0, 255, 8'h00};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_out%0d", i),
                {26'd0, s_ready_w[i], wr_w[i], busy_w[i], done_w[i], lab_w[i], |data_w[i]}, 32'd0);
        end

        // start together with abort in IDLE must be ignored
        @(negedge clk); start = 1'b1; abort = 1'b1; wave_sel = 2'd2;
        @(posedge clk); #1;
        chk("start_abort_idle_busy", busy_w[0], 0);
        @(negedge clk); start = 1'b0; abort = 1'b0;

        // table-driven shape points
        for (int i = 0; i < 19; i++) begin
            if (i == 0 || vt[i].sel != vt[i-1].sel || vt[i].dty != vt[i-1].dty || vt[i].g != vt[i-1].g)
                run_load($sformatf("tbl%0d", i), vt[i].g, vt[i].sel, vt[i].dty, 0, -1, 0, 1);
            chk($sformatf("vec%0d_idx%0d", i, vt[i].idx), cap[vt[i].idx], vt[i].exp);
        end

        for (int r = 0; r < 3; r++)
            run_load($sformatf("sq_rand%0d", r), $urandom_range(2), 2'd0, 8'($urandom), 0, -1, 0, 1);
        run_load("tri_restart", 0, 2'd1, 8'h00, 0, -1, 1, 1);
        run_load("stream", 1, 2'd3, 8'h00, 60, -1, 0, 1);
        run_load("stream_abort", 1, 2'd3, 8'h00, 70, 100, 0, 1);
        repeat (3) @(negedge clk);
        chk("abort_lab_held", lab_w[1], 1);
        run_load("after_abort", 1, 2'd1, 8'h00, 0, -1, 0, 0);

        g = 2;
        run_load("gen_abort", g, 2'($urandom_range(2)), 8'($urandom), 0, $urandom_range(1, 200), 0, 1);
        do_reset();
        chk("rst_clears_lab", lab_w[2], 0);

        // reset in the middle of a sawtooth load
        @(negedge clk); start = 1'b1; wave_sel = 2'd2;
        @(negedge clk); start = 1'b0;
        pc = 0; cyc = 0;
        while (pc < 50 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (wr_w[0]) pc++;
        end
        chk("mid_rst_reach50", pc, 50);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_out", {27'd0, s_ready_w[0], wr_w[0], busy_w[0], done_w[0], lab_w[0]}, 32'd0);
        chk("mid_rst_data", data_w[0], 0);
        @(negedge clk); rst = 1'b0;
        run_load("saw_fresh", 0, 2'd2, 8'h00, 0, -1, 0, 0);
        chk("saw_fresh_first", cap[0], 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
